bus_ram: RTL
============

# bus_ram

Addressable data store that sits on the CPU's shared bus at the far end of the memory address register. It takes the latched address and either drives the addressed word onto the bus or captures the bus into that word. A built-in program loader fills memory word by word over a valid/ready handshake before the CPU runs.

## Interface
Parameters:
- ADDRESS_WIDTH, 4, address bits; depth = 2**ADDRESS_WIDTH words
- DATA_WIDTH, 8, word and bus width

Ports:
- i_CLOCK  in  1  single clock; all state updates on rising edge
- i_CLEAR  in  1  reset, asynchronous, active-high
- i_ADDRESS  in  ADDRESS_WIDTH  word address, driven by the address register output
- i_BUS  in  DATA_WIDTH  shared bus value
- i_READ_BUS  in  1  capture i_BUS into mem[i_ADDRESS] at next edge
- i_WRITE_BUS  in  1  drive mem[i_ADDRESS] onto bus
- o_BUS  out  DATA_WIDTH  bus drive value; all zeros when o_BUS_EN=0
- o_BUS_EN  out  1  bus drive enable
- i_PROG_MODE  in  1  request loader operation
- i_PROG_VALID  in  1  loader word valid
- i_PROG_DATA  in  DATA_WIDTH  loader word
- o_PROG_READY  out  1  loader accepts a word this cycle
- o_PROG_DONE  out  1  all words loaded

## Operation
- Loader FSM states: IDLE, LOAD, DONE; load pointer ptr is ADDRESS_WIDTH bits wide.
- IDLE -> LOAD when i_PROG_MODE=1; ptr=0 on entry.
- In LOAD, o_PROG_READY=1. A word is accepted on an edge with i_PROG_VALID & o_PROG_READY: mem[ptr]<=i_PROG_DATA, ptr<=ptr+1.
- Accepting at ptr=2**ADDRESS_WIDTH-1 -> DONE. ptr wraps to 0; no extra write occurs.
- LOAD or DONE -> IDLE when i_PROG_MODE=0, checked before any accept that cycle. A partial load leaves the written words in place; re-entry restarts at 0.
- DONE: o_PROG_DONE=1 and o_PROG_READY=0; stays in DONE while i_PROG_MODE=1.
- CPU access, only in IDLE:
  - o_BUS_EN = i_WRITE_BUS; o_BUS = mem[i_ADDRESS] when enabled.
  - i_READ_BUS=1 writes i_BUS to mem[i_ADDRESS] at the edge.
- In LOAD/DONE, i_READ_BUS and i_WRITE_BUS are ignored; o_BUS_EN=0.
- i_READ_BUS and i_WRITE_BUS both high: o_BUS carries the old word during the cycle (read-before-write); the new word is visible after the edge.
- i_CLEAR: state=IDLE, ptr=0, o_PROG_READY=0, o_PROG_DONE=0, o_BUS_EN=0, o_BUS=0.
  - Memory contents are not cleared; simulation initial contents are all zeros.
  - Clear mid-load aborts the load immediately; words already written are kept.

## Timing
- Read path is combinational from i_ADDRESS/i_WRITE_BUS to o_BUS, zero latency (same-cycle bus transfer).
- Write latency is 1 edge; a read of the same address is valid the cycle after the write.
- Loader throughput is one word per cycle with valid held high. Full load takes 2**ADDRESS_WIDTH accepting edges; o_PROG_DONE rises right after the last accept.
- o_PROG_READY and o_PROG_DONE are registered state decodes: no combinational path from i_PROG_VALID.
- FSM, ptr and memory writes are rising-edge only, except the asynchronous clear.

## Configuration
- BUS_RAM_LOADER_EN defined: loader FSM, ptr and PROG ports are functional as described.
- BUS_RAM_LOADER_EN undefined:
  - PROG ports remain for a fixed interface; inputs are ignored, o_PROG_READY=0, o_PROG_DONE=0.
  - Block is permanently in IDLE behaviour; memory is written only via i_READ_BUS.

## Structure
- Shared package bus_ram_pkg holds the loader state enum (IDLE, LOAD, DONE) and a constant for the default data width.
- One sub-module, bus_ram_loader: FSM plus ptr.
  - Outputs a write enable, write address, write data and a busy flag.
  - Top level muxes loader writes against CPU writes and gates bus drive with busy.

## Test plan
- Clear asserted mid-cycle, no clock edge: o_BUS_EN=0, o_PROG_READY=0, o_PROG_DONE=0 immediately.
- PROG_MODE=1 with VALID held and data 0x10..0x1F over 16 cycles: o_PROG_DONE=1 after the 16th accept. Then PROG_MODE=0, address 5, WRITE_BUS=1: o_BUS=0x15, o_BUS_EN=1.
- IDLE, address 3, bus 0xA5, READ_BUS=1 for one edge, then WRITE_BUS=1: o_BUS=0xA5.
- READ_BUS and WRITE_BUS both high, address 3, bus 0x3C, old word 0xA5: o_BUS=0xA5 that cycle, 0x3C the next.
- Load 4 words, pulse i_CLEAR, re-enter PROG_MODE: state IDLE after clear, first accept writes address 0, words 0-3 kept until overwritten.
- During LOAD, WRITE_BUS=1 and READ_BUS=1 with bus 0xFF: o_BUS_EN=0 and no CPU write occurs.

Source files
------------

// File: rtl/bus_ram_pkg.sv
// Shared types and constants for the bus_ram block.
package bus_ram_pkg;

  localparam int DEFAULT_ADDRESS_WIDTH = 4;
  localparam int DEFAULT_DATA_WIDTH    = 8;

  // Program loader states; IDLE is also the only state in which the CPU may
  // touch memory.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } loader_state_t;

endpackage

// File: rtl/bus_ram_if.sv
// Bus and program-loader signal bundle for bus_ram.
// Port names keep the i_/o_ prefixes as seen from the RAM.
//
// Loader handshake: a word on i_PROG_DATA transfers on a rising edge where
// i_PROG_VALID and o_PROG_READY are both high. o_PROG_READY is a registered
// state decode and never depends on i_PROG_VALID in the same cycle; the
// source may hold VALID high and change DATA after every accepting edge.
interface bus_ram_if #(
  parameter int ADDRESS_WIDTH = 4,
  parameter int DATA_WIDTH    = 8
);
  logic [ADDRESS_WIDTH-1:0] i_ADDRESS;
  logic [DATA_WIDTH-1:0]    i_BUS;
  logic                     i_READ_BUS;
  logic                     i_WRITE_BUS;
  logic [DATA_WIDTH-1:0]    o_BUS;
  logic                     o_BUS_EN;
  logic                     i_PROG_MODE;
  logic                     i_PROG_VALID;
  logic [DATA_WIDTH-1:0]    i_PROG_DATA;
  logic                     o_PROG_READY;
  logic                     o_PROG_DONE;

  // RAM side
  modport slave (
    input  i_ADDRESS, i_BUS, i_READ_BUS, i_WRITE_BUS,
    input  i_PROG_MODE, i_PROG_VALID, i_PROG_DATA,
    output o_BUS, o_BUS_EN, o_PROG_READY, o_PROG_DONE
  );

  // CPU / loader-source side
  modport master (
    output i_ADDRESS, i_BUS, i_READ_BUS, i_WRITE_BUS,
    output i_PROG_MODE, i_PROG_VALID, i_PROG_DATA,
    input  o_BUS, o_BUS_EN, o_PROG_READY, o_PROG_DONE
  );
endinterface

// File: rtl/bus_ram_loader.sv
// Program loader: fills memory word by word from address 0 upward.
// Produces a write port for the top level plus a busy flag that locks the CPU
// out of memory while a load session (LOAD or DONE) is open.
module bus_ram_loader
  import bus_ram_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH
) (
  input  logic                     i_CLOCK,
  input  logic                     i_CLEAR,
  input  logic                     i_prog_mode,
  input  logic                     i_prog_valid,
  input  logic [DATA_WIDTH-1:0]    i_prog_data,
  output logic                     o_we,
  output logic [ADDRESS_WIDTH-1:0] o_waddr,
  output logic [DATA_WIDTH-1:0]    o_wdata,
  output logic                     o_busy,
  output logic                     o_ready,
  output logic                     o_done,
  output loader_state_t            o_state
);

  loader_state_t            state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] ptr_q, ptr_d;
  logic                     accept;

  // State and pointer registers; clear aborts any load in progress.
  always_ff @(posedge i_CLOCK or posedge i_CLEAR) begin
    if (i_CLEAR) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next state; dropping PROG_MODE wins over an accept in the same cycle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        ptr_d = '0;
        if (i_prog_mode) state_d = LOAD;
      end
      LOAD: begin
        if (!i_prog_mode) begin
          state_d = IDLE;
        end else if (i_prog_valid) begin
          accept = 1'b1;
          ptr_d  = ptr_q + 1'b1;
          if (ptr_q == '1) state_d = DONE;
        end
      end
      DONE: begin
        if (!i_prog_mode) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_we    = accept;
  assign o_waddr = ptr_q;
  assign o_wdata = i_prog_data;
  assign o_busy  = (state_q != IDLE);
  assign o_ready = (state_q == LOAD);
  assign o_done  = (state_q == DONE);
  assign o_state = state_q;

endmodule

// File: rtl/bus_ram.sv
// Bus-attached word memory with combinational bus read, one-edge write and an
// optional program loader (enabled by defining BUS_RAM_LOADER_EN). Without the
// macro the PROG ports stay on the interface but are ignored and the block
// behaves as a plain CPU-accessed RAM.
module bus_ram
  import bus_ram_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH
) (
  input  logic          i_CLOCK,
  input  logic          i_CLEAR,
  bus_ram_if.slave      bus,
  output loader_state_t o_DBG_STATE
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;

  logic [DATA_WIDTH-1:0]    mem_q [DEPTH];
  logic                     ldr_we;
  logic [ADDRESS_WIDTH-1:0] ldr_waddr;
  logic [DATA_WIDTH-1:0]    ldr_wdata;
  logic                     ldr_busy;
  logic                     ldr_ready;
  logic                     ldr_done;
  loader_state_t            ldr_state;
  logic                     mem_we;
  logic [ADDRESS_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic                     bus_en;

`ifdef BUS_RAM_LOADER_EN
  bus_ram_loader #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH)
  ) u_loader (
    .i_CLOCK      (i_CLOCK),
    .i_CLEAR      (i_CLEAR),
    .i_prog_mode  (bus.i_PROG_MODE),
    .i_prog_valid (bus.i_PROG_VALID),
    .i_prog_data  (bus.i_PROG_DATA),
    .o_we         (ldr_we),
    .o_waddr      (ldr_waddr),
    .o_wdata      (ldr_wdata),
    .o_busy       (ldr_busy),
    .o_ready      (ldr_ready),
    .o_done       (ldr_done),
    .o_state      (ldr_state)
  );
`else
  // Loader absent: the PROG inputs are only folded into a sink.
  logic unused_prog;
  assign unused_prog = ^{bus.i_PROG_MODE, bus.i_PROG_VALID, bus.i_PROG_DATA};
  assign ldr_we      = 1'b0;
  assign ldr_waddr   = '0;
  assign ldr_wdata   = '0;
  assign ldr_busy    = 1'b0;
  assign ldr_ready   = 1'b0;
  assign ldr_done    = 1'b0;
  assign ldr_state   = IDLE;
`endif

  // Write-port select: loader has the memory while busy, otherwise the CPU.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bus.i_ADDRESS;
    mem_wdata = bus.i_BUS;
    if (ldr_busy) begin
      mem_we    = ldr_we;
      mem_waddr = ldr_waddr;
      mem_wdata = ldr_wdata;
    end else if (bus.i_READ_BUS && !i_CLEAR) begin
      mem_we = 1'b1;
    end
  end

  // Memory array; contents deliberately survive clear.
  always_ff @(posedge i_CLOCK) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  // Same-cycle bus drive; the old word is driven even when a write is pending.
  always_comb begin
    bus_en = bus.i_WRITE_BUS && !ldr_busy && !i_CLEAR;
  end

  assign bus.o_BUS        = bus_en ? mem_q[bus.i_ADDRESS] : '0;
  assign bus.o_BUS_EN     = bus_en;
  assign bus.o_PROG_READY = ldr_ready && !i_CLEAR;
  assign bus.o_PROG_DONE  = ldr_done && !i_CLEAR;
  assign o_DBG_STATE      = ldr_state;

endmodule
